apb_master_bridge: RTL

Single-outstanding APB initiator. It converts a simple valid/ready command stream into APB SETUP/ACCESS transfers toward one responder, such as the apb_gpio1 GPIO slave, and returns read data and error status on a valid/ready response stream. It replaces hand-sequenced bus stimulus with a synthesizable master. Wait states and PSLVERR are honoured, and a stuck-bus timeout is enforced.

---
 rtl/apb_master_pkg.sv | 25 ++
 rtl/apb_wait_timer.sv | 33 +++
 rtl/apb_master_bridge.sv | 135 +++++++++++++
 3 files changed

// File: rtl/apb_master_pkg.sv
// Shared types and default sizes for the APB master bridge.
// No logic; latency not applicable.
// No flow control; pure type/constant definitions.
package apb_master_pkg;

  localparam int DEF_PDATA_SIZE     = 32;
  localparam int DEF_PADDR_SIZE     = 4;
  localparam int DEF_TIMEOUT_CYCLES = 16;

  // Transfer sequencing: command wait, APB setup, APB access, response hold.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Response payload at the default data width.
  typedef struct packed {
    logic [DEF_PDATA_SIZE-1:0] rdata;
    logic                      err;
    logic                      timeout;
  } rsp_t;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS-phase wait states and flags when the next wait would hit LIMIT.
// expired is combinational from the current count and en; count updates on clk.
// No flow control; clr has priority over en, LIMIT = 0 never expires.
module apb_wait_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = ($clog2(LIMIT + 1) > 0) ? $clog2(LIMIT + 1) : 1;
  localparam logic [CW:0] LIM = (CW + 1)'(LIMIT);

  logic [CW-1:0] cnt;

  // Wait counter: cleared when a transfer starts, bumped on each stalled ACCESS edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  // The edge that would bring the count to LIMIT is the abort edge.
  assign expired = en && (LIM != '0) && (({1'b0, cnt} + (CW + 1)'(1)) == LIM);

endmodule

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB initiator: valid/ready command in, APB transfer, valid/ready response out.
// Zero-wait latency: accept at edge N, PSEL from N, PENABLE from N+1, rsp_valid from N+2; +1 per wait state.
// cmd_ready only in IDLE; the response is held stable until rsp_ready, then IDLE one cycle later.
module apb_master_bridge
  import apb_master_pkg::*;
#(
  parameter int PDATA_SIZE     = DEF_PDATA_SIZE,
  parameter int PADDR_SIZE     = DEF_PADDR_SIZE,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [PADDR_SIZE-1:0]   cmd_addr,
  input  logic [PDATA_SIZE-1:0]   cmd_wdata,
  input  logic [PDATA_SIZE/8-1:0] cmd_strb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [PDATA_SIZE-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [PADDR_SIZE-1:0]   PADDR,
  output logic [PDATA_SIZE-1:0]   PWDATA,
  output logic [PDATA_SIZE/8-1:0] PSTRB,
  input  logic [PDATA_SIZE-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);

  state_t state, state_nxt;
  logic   timer_clr, timer_en, timer_expired;

  apb_wait_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk    (PCLK),
    .rst    (PRESET),
    .clr    (timer_clr),
    .en     (timer_en),
    .expired(timer_expired)
  );

  // State register; reset abandons any transfer or pending response.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and state-decoded outputs. PSEL/PENABLE come straight from the
  // registered state so they are glitch-free and never 1/1 outside ACCESS.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    PSEL      = 1'b0;
    PENABLE   = 1'b0;
    timer_clr = 1'b0;
    timer_en  = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_nxt = SETUP;
          timer_clr = 1'b1;
        end
      end
      SETUP: begin
        PSEL      = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        // PREADY wins over an expiring timer on the same edge.
        if (PREADY) begin
          state_nxt = RESP;
        end else begin
          timer_en = 1'b1;
          if (timer_expired) begin
            state_nxt = RESP;
          end
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture on accept and response capture on completion or abort.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      PSTRB       <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      if (state == IDLE && cmd_valid) begin
        PWRITE <= cmd_write;
        PADDR  <= cmd_addr;
        PWDATA <= cmd_wdata;
        // Reads carry no byte lanes.
        PSTRB  <= cmd_write ? cmd_strb : '0;
      end
      if (state == ACCESS) begin
        if (PREADY) begin
          // PSEL and PENABLE are both high here, so PSLVERR is valid to sample.
          rsp_rdata   <= PWRITE ? '0 : PRDATA;
          rsp_err     <= PSLVERR;
          rsp_timeout <= 1'b0;
        end else if (timer_expired) begin
          rsp_rdata   <= '0;
          rsp_err     <= 1'b1;
          rsp_timeout <= 1'b1;
        end
      end
    end
  end

endmodule
